jt12_pg_pipe: RTL and testbench
===============================

// Module: jt12_pg_pipe
// PURPOSE
// Time-multiplexed phase generator pipeline for the 24 FM operator slots (6 ch x 4 op).
// Registers the per-slot phase-step terms, holds each slot's 20-bit phase accumulator in a circular store,
// and emits the 10-bit operator phase to the operator (sine/log) stage, plus keycode to the envelope generator.
// Wraps the combinational phase-step arithmetic with slot sequencing and two pipeline stages.
// PARAMETERS
// SLOTS    24  operator slots per sample frame; slot counter wraps SLOTS-1 -> 0
// PHASE_W  20  phase accumulator width; phase_op = phase[PHASE_W-1 -: 10]
// PORTS
// clk        in   1   system clock
// rst_n      in   1   asynchronous reset, active low
// clk_en     in   1   slot advance strobe; all state holds when low
// zero       in   1   frame marker: the slot sampled on this clk_en is slot 0
// block      in   3   octave of slot at stage I
// fnum       in   11  frequency number of slot at stage I
// lfo_mod    in   5   LFO phase-modulation index
// pms        in   3   PM sensitivity; 0 disables PM
// detune     in   3   DT1 field
// mul        in   4   MUL field; 0 means x0.5
// pg_rst     in   1   key-on restart, aligned to the slot in stage II
// keycode    out  5   keycode of slot in stage I, registered
// phase_op   out  10  operator phase of slot leaving stage II
// slot_out   out  5   slot index associated with phase_op
// op_valid   out  1   phase_op updated on this clk_en (first full frame after reset)
// sync_err   out  1   one-clk pulse: zero arrived while counter != 0
// BEHAVIOUR
// - Reset (rst_n low, async): counter, all pipeline regs, whole phase store, all outputs = 0; takes effect immediately.
// - Slot counter cnt: on clk_en, cnt <= (cnt==SLOTS-1) ? 0 : cnt+1.
// - zero on clk_en: the current slot is treated as 0 and cnt <= 1.
//   If cnt != 0 at that edge, sync_err pulses high for one clk.
// - Stage I (clk_en edge n): register the following for the current slot:
//   - phinc = ((fnum + pm_offset) << block) >> 1, 17 bits; pm_offset = 0 when pms = 0.
//   - detune_signed, 6 bits signed, from block/fnum/detune.
//   - keycode, mul, slot index.
// - Stage II (edge n+1): step = (phinc + detune_signed) mod 2^17.
//   - mul = 0: step >> 1; otherwise step * mul.
//   - phase_new = pg_rst ? 0 : (phase_old + step) mod 2^PHASE_W.
// - Phase store: SLOTS-deep shift register advancing on clk_en.
//   - Head = phase_old of the stage II slot; phase_new is written at the tail.
//   - Read-after-write distance is exactly SLOTS clk_en.
// - Output (edge n+2): phase_op <= phase_new[PHASE_W-1 -: 10]; slot_out <= stage II slot.
//   - Latency: inputs at edge n -> phase_op at edge n+2.
// - op_valid: 0 after reset; set once SLOTS+2 clk_en have elapsed.
// - clk_en low: no register changes; sync_err still clears.
// - pg_rst with clk_en low: ignored.
// - Accumulator wrap is silent modulo 2^PHASE_W.
// - zero asserted on consecutive clk_en: each forces slot 0.
// TESTING
// - Reset, then fnum=0x400, block=4, pms=0, dt=0, mul=1 on all slots, zero every 24th clk_en:
//   slot 0 phase_op = 8, 16, 24 on successive frames.
// - Same stimulus with mul=0: phase_op increments by 4 per frame; with mul=15: 120 per frame (wraps at 1024).
// - pg_rst on slot 5 only, in frame 3: slot 5 phase_op = 0 that frame, then 8; other slots unaffected.
// - zero injected at cnt=10: sync_err pulses once, slot_out restarts at 0 two clk_en later, no X on outputs.
// - clk_en held low 50 clk mid-frame: all outputs and the phase store unchanged; resumes from the same slot.
// - rst_n pulsed low mid-frame: outputs immediately 0; op_valid = 0 until SLOTS+2 clk_en after release.

Source files
------------

// File: rtl/jt12_pg_pipe_if.sv
// Slot-data bus between the phase-generator sequencer and the FM
// operator pipeline: per-slot frequency inputs plus the phase outputs.
interface jt12_pg_pipe_if;
  logic        zero;
  logic [2:0]  block;
  logic [10:0] fnum;
  logic [4:0]  lfo_mod;
  logic [2:0]  pms;
  logic [2:0]  detune;
  logic [3:0]  mul;
  logic        pg_rst;
  logic [4:0]  keycode;
  logic [9:0]  phase_op;
  logic [4:0]  slot_out;
  logic        op_valid;
  logic        sync_err;

  modport master (
    output zero, block, fnum, lfo_mod, pms, detune, mul, pg_rst,
    input  keycode, phase_op, slot_out, op_valid, sync_err
  );

  modport slave (
    input  zero, block, fnum, lfo_mod, pms, detune, mul, pg_rst,
    output keycode, phase_op, slot_out, op_valid, sync_err
  );
endinterface

// File: rtl/jt12_pg_pipe.sv
// Time-multiplexed phase generator for the 24 FM operator slots.
// Stage I registers the phase-step terms of the incoming slot, stage II
// applies detune/MUL and accumulates into a circular per-slot phase store,
// and the output stage presents the top 10 phase bits to the operator.
module jt12_pg_pipe #(
  parameter int unsigned SLOTS   = 24,
  parameter int unsigned PHASE_W = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  jt12_pg_pipe_if.slave pg
);

  localparam int unsigned VW = $clog2(SLOTS + 3);

  // DT1 magnitude, YM2612 table indexed by keycode; rows packed {dt1,dt2,dt3}
  function automatic logic [4:0] dt_mag(input logic [4:0] kc, input logic [1:0] d);
    logic [14:0] row;
    case (kc)
      5'd0, 5'd1, 5'd2, 5'd3: row = {5'd0, 5'd1,  5'd2};
      5'd4:                   row = {5'd1, 5'd2,  5'd2};
      5'd5, 5'd6, 5'd7:       row = {5'd1, 5'd2,  5'd3};
      5'd8:                   row = {5'd1, 5'd2,  5'd4};
      5'd9, 5'd10:            row = {5'd1, 5'd3,  5'd4};
      5'd11:                  row = {5'd1, 5'd3,  5'd5};
      5'd12:                  row = {5'd2, 5'd4,  5'd5};
      5'd13, 5'd14:           row = {5'd2, 5'd4,  5'd6};
      5'd15:                  row = {5'd2, 5'd5,  5'd7};
      5'd16:                  row = {5'd2, 5'd5,  5'd8};
      5'd17:                  row = {5'd3, 5'd6,  5'd8};
      5'd18:                  row = {5'd3, 5'd6,  5'd9};
      5'd19:                  row = {5'd3, 5'd7,  5'd10};
      5'd20:                  row = {5'd4, 5'd8,  5'd11};
      5'd21:                  row = {5'd4, 5'd8,  5'd12};
      5'd22:                  row = {5'd4, 5'd9,  5'd13};
      5'd23:                  row = {5'd5, 5'd10, 5'd14};
      5'd24:                  row = {5'd5, 5'd11, 5'd16};
      5'd25:                  row = {5'd6, 5'd12, 5'd17};
      5'd26:                  row = {5'd6, 5'd13, 5'd19};
      5'd27:                  row = {5'd7, 5'd14, 5'd20};
      default:                row = {5'd8, 5'd16, 5'd22};
    endcase
    case (d)
      2'd1:    return row[14:10];
      2'd2:    return row[9:5];
      2'd3:    return row[4:0];
      default: return 5'd0;
    endcase
  endfunction

  logic [4:0]         cnt;
  logic [4:0]         cur_slot;
  logic [VW-1:0]      vcnt;

  logic [10:0]        pm_prod;
  logic [10:0]        pm_mag;
  logic [11:0]        fsum;
  logic [16:0]        phinc_c;
  logic [4:0]         kc_c;
  logic [4:0]         dtm_c;
  logic signed [5:0]  dt_c;

  logic [16:0]        phinc_i;
  logic signed [5:0]  dt_i;
  logic [3:0]         mul_i;
  logic [4:0]         slot_i;

  logic [16:0]        step17;
  logic [PHASE_W-1:0] step_w;
  logic [PHASE_W-1:0] phase_new;
  logic [PHASE_W-1:0] store [SLOTS];

  logic [9:0]         ph_ii;
  logic [4:0]         slot_ii;

  assign cur_slot = pg.zero ? 5'd0 : cnt;

  // Stage I arithmetic: LFO-modulated fnum, octave shift, keycode, detune
  always_comb begin
    pm_prod = {4'd0, pg.fnum[10:4]} * {7'd0, pg.lfo_mod[3:0]};
    pm_mag  = '0;
    if (pg.pms != 3'd0)
      pm_mag = pm_prod >> (4'd10 - {1'b0, pg.pms});
    // pm_mag stays below fnum, so the downward swing cannot underflow
    fsum    = pg.lfo_mod[4] ? ({1'b0, pg.fnum} - {1'b0, pm_mag})
                            : ({1'b0, pg.fnum} + {1'b0, pm_mag});
    phinc_c = 17'(({7'd0, fsum} << pg.block) >> 1);
    kc_c    = {pg.block, pg.fnum[10],
               (pg.fnum[10] & (|pg.fnum[9:7])) | (~pg.fnum[10] & (&pg.fnum[9:7]))};
    dtm_c   = dt_mag(kc_c, pg.detune[1:0]);
    dt_c    = pg.detune[2] ? 6'(-{1'b0, dtm_c}) : {1'b0, dtm_c};
  end

  // Stage II arithmetic: detuned step, MUL scaling, accumulate or restart
  always_comb begin
    step17    = phinc_i + {{11{dt_i[5]}}, dt_i};
    step_w    = (mul_i == 4'd0) ? PHASE_W'(step17 >> 1)
                                : PHASE_W'({4'd0, step17} * {17'd0, mul_i});
    phase_new = pg.pg_rst ? '0 : store[SLOTS-1] + step_w;
  end

  // Slot sequencing, frame-sync error pulse and output-valid qualification
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      vcnt        <= '0;
      pg.op_valid <= 1'b0;
      pg.sync_err <= 1'b0;
    end else begin
      pg.sync_err <= clk_en && pg.zero && (cnt != 5'd0);
      if (clk_en) begin
        if (pg.zero)                   cnt <= 5'd1;
        else if (cnt == 5'(SLOTS - 1)) cnt <= '0;
        else                           cnt <= cnt + 5'd1;
        if (!pg.op_valid) begin
          vcnt <= vcnt + 1'b1;
          if (vcnt == VW'(SLOTS + 1))
            pg.op_valid <= 1'b1;
        end
      end
    end
  end

  // Pipeline registers: stage I, stage II and the operator-facing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phinc_i     <= '0;
      dt_i        <= '0;
      mul_i       <= '0;
      slot_i      <= '0;
      pg.keycode  <= '0;
      ph_ii       <= '0;
      slot_ii     <= '0;
      pg.phase_op <= '0;
      pg.slot_out <= '0;
    end else if (clk_en) begin
      phinc_i     <= phinc_c;
      dt_i        <= dt_c;
      mul_i       <= pg.mul;
      slot_i      <= cur_slot;
      pg.keycode  <= kc_c;
      ph_ii       <= phase_new[PHASE_W-1 -: 10];
      slot_ii     <= slot_i;
      pg.phase_op <= ph_ii;
      pg.slot_out <= slot_ii;
    end
  end

  // Circular phase store: head feeds stage II, new phase enters at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SLOTS; i++)
        store[i] <= '0;
    end else if (clk_en) begin
      for (int unsigned i = SLOTS - 1; i > 0; i--)
        store[i] <= store[i-1];
      store[0] <= phase_new;
    end
  end

endmodule

// File: tb/tb_jt12_pg_pipe.sv
// Scoreboard bench for jt12_pg_pipe: the stimulus process drives one slot
// per clk_en and queues expected keycode/sync and phase/slot results; the
// monitor pops and compares at each enabled edge.
module tb_jt12_pg_pipe;

  typedef struct packed { logic [4:0] kc; logic serr; } kent_t;
  typedef struct packed { logic [4:0] slot; logic [9:0] ph; } pent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;

  jt12_pg_pipe_if pg();

  jt12_pg_pipe #(.SLOTS(24), .PHASE_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .pg(pg)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  kent_t       kq[$];
  pent_t       pq[$];
  logic [19:0] ring[$];
  logic [4:0]  m_cnt;
  bit          prev_rst;

  logic [10:0] s_fnum;
  logic [2:0]  s_block;
  logic [3:0]  s_mul;
  logic [2:0]  s_dt;
  logic [4:0]  s_kc;
  logic [19:0] s_step;

  logic [9:0]  last_ph;
  logic [4:0]  last_slot;
  logic [4:0]  last_kc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    kq.delete();
    pq.delete();
    ring.delete();
    for (int i = 0; i < 24; i++) ring.push_back(20'd0);
    m_cnt    = 5'd0;
    prev_rst = 1'b0;
  endtask

  // One slot on one clk_en; expected results derived from hand-set step
  task automatic issue(input bit z, input bit rs);
    logic [4:0]  sl;
    bit          se;
    logic [19:0] old_ph, new_ph;
    @(negedge clk);
    pg.zero    = z;
    pg.fnum    = s_fnum;
    pg.block   = s_block;
    pg.mul     = s_mul;
    pg.detune  = s_dt;
    pg.lfo_mod = 5'd0;
    pg.pms     = 3'd0;
    pg.pg_rst  = prev_rst;
    clk_en     = 1'b1;
    sl = z ? 5'd0 : m_cnt;
    se = z && (m_cnt != 5'd0);
    if (z) m_cnt = 5'd1;
    else   m_cnt = (m_cnt == 5'd23) ? 5'd0 : m_cnt + 5'd1;
    old_ph = ring.pop_front();
    new_ph = rs ? 20'd0 : old_ph + s_step;
    ring.push_back(new_ph);
    kq.push_back('{kc: s_kc, serr: se});
    pq.push_back('{slot: sl, ph: new_ph[19:10]});
    prev_rst = rs;
  endtask

  task automatic run_frame(input int rst_slot);
    for (int i = 0; i < 24; i++) issue(i == 0, i == rst_slot);
  endtask

  task automatic set_base(input logic [3:0] m, input logic [2:0] d, input logic [19:0] st);
    s_fnum = 11'h400; s_block = 3'd4; s_kc = 5'd18;
    s_mul = m; s_dt = d; s_step = st;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_phase_op"}, 32'(pg.phase_op), 32'd0);
    chk({tag, "_slot_out"}, 32'(pg.slot_out), 32'd0);
    chk({tag, "_keycode"},  32'(pg.keycode),  32'd0);
    chk({tag, "_op_valid"}, 32'(pg.op_valid), 32'd0);
    chk({tag, "_sync_err"}, 32'(pg.sync_err), 32'd0);
  endtask

  // Monitor: compares DUT outputs against queued expectations each clk_en
  initial begin : monitor
    int unsigned e;
    bit          en_s, rst_s;
    kent_t       k;
    pent_t       p;
    e = 0;
    forever begin
      @(posedge clk);
      en_s  = clk_en;
      rst_s = rst_n;
      #1;
      if (!rst_n) begin
        e = 0;
      end else if (en_s && rst_s) begin
        e++;
        chk("no_x", 32'($isunknown({pg.keycode, pg.phase_op, pg.slot_out,
                                    pg.op_valid, pg.sync_err})), 32'd0);
        chk("op_valid", 32'(pg.op_valid), 32'(e >= 26));
        chk("kq_nonempty", 32'(kq.size() != 0), 32'd1);
        if (kq.size() != 0) begin
          k = kq.pop_front();
          chk("keycode", 32'(pg.keycode), 32'(k.kc));
          chk("sync_err", 32'(pg.sync_err), 32'(k.serr));
          last_kc = k.kc;
        end
        if (e >= 3) begin
          chk("pq_nonempty", 32'(pq.size() != 0), 32'd1);
          if (pq.size() != 0) begin
            p = pq.pop_front();
            chk("slot_out", 32'(pg.slot_out), 32'(p.slot));
            chk("phase_op", 32'(pg.phase_op), 32'(p.ph));
            last_ph   = p.ph;
            last_slot = p.slot;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout expected=done");
    $fatal(1);
  end

  // Stimulus sequence
  initial begin : stim
    rst_n = 1'b0; clk_en = 1'b0;
    pg.zero = 1'b0; pg.fnum = '0; pg.block = '0; pg.lfo_mod = '0;
    pg.pms = '0; pg.detune = '0; pg.mul = '0; pg.pg_rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1024<<4>>1 = 8192 per frame -> phase_op 8,16,24; slot 5 restarted in frame 3
    set_base(4'd1, 3'd0, 20'd8192);
    run_frame(-1); run_frame(-1); run_frame(5); run_frame(-1);

    // MUL=0 halves the step: +4 per frame
    set_base(4'd0, 3'd0, 20'd4096);
    run_frame(-1); run_frame(-1);

    // MUL=15: +120 per frame, wrapping past 1024
    set_base(4'd15, 3'd0, 20'd122880);
    for (int f = 0; f < 10; f++) run_frame(-1);

    // Keycode 18 detune magnitude 3: DT=5 subtracts, DT=1 adds
    set_base(4'd1, 3'd5, 20'd8189);
    run_frame(-1);
    set_base(4'd1, 3'd1, 20'd8195);
    run_frame(-1);

    // Top octave, fnum 0x7FF: keycode 31, step (2047<<7)>>1 = 131008
    s_fnum = 11'h7FF; s_block = 3'd7; s_kc = 5'd31;
    s_mul = 4'd1; s_dt = 3'd0; s_step = 20'd131008;
    run_frame(-1); run_frame(-1);

    // zero injected at cnt=10: one sync_err pulse, slot numbering restarts
    set_base(4'd1, 3'd0, 20'd8192);
    for (int i = 0; i < 10; i++) issue(i == 0, 1'b0);
    issue(1'b1, 1'b0);
    for (int i = 0; i < 23; i++) issue(1'b0, 1'b0);
    run_frame(-1);

    // clk_en low for 50 clocks mid-frame; zero and pg_rst must be ignored
    for (int i = 0; i < 12; i++) issue(i == 0, 1'b0);
    @(negedge clk);
    clk_en = 1'b0; pg.zero = 1'b1; pg.pg_rst = 1'b1;
    repeat (50) @(negedge clk);
    chk("hold_phase_op", 32'(pg.phase_op), 32'(last_ph));
    chk("hold_slot_out", 32'(pg.slot_out), 32'(last_slot));
    chk("hold_keycode",  32'(pg.keycode),  32'(last_kc));
    chk("hold_sync_err", 32'(pg.sync_err), 32'd0);
    chk("hold_op_valid", 32'(pg.op_valid), 32'd1);
    for (int i = 12; i < 24; i++) issue(1'b0, 1'b0);
    run_frame(-1);

    // Asynchronous reset mid-frame: outputs clear before any clock edge
    for (int i = 0; i < 7; i++) issue(i == 0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    clk_en = 1'b0; pg.zero = 1'b0; pg.pg_rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    set_base(4'd1, 3'd0, 20'd8192);
    run_frame(-1); run_frame(-1);

    @(negedge clk);
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
